// File: rtl/mem_access.sv
// mem_access -- memory-stage access unit.
// Takes the EX/MEM register outputs, runs one data-memory access per
// instruction over a req/ack handshake, stalls the front of the pipeline
// while the access is outstanding and registers the result toward WB.
// All state updates on the falling edge of Clk; Reset is async active-low.
//
// Ports:
//   Clk, Reset                      clock (negedge), async active-low reset
//   mem_*                           EX/MEM register outputs
//   dm_req/we/addr/be/wdata         data-memory request (held until dm_ack)
//   dm_ack, dm_rdata                data-memory response
//   stall                           combinational pipeline hold
//   wb_valid/Rw/RegWr/data          registered write-back slot
//   exc_ades/adel/bus, exc_badvaddr exception pulses aligned with wb_valid
//
// Parameter TIMEOUT_CYCLES: ACCESS cycles without ack before a bus error
// (0 disables the watchdog).
// Optional feature macro MEM_ALIGN_CHECK_EN: trap misaligned half/word
// accesses instead of masking the low address bits.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_busB,
  input  logic [1:0]  mem_MemWr,
  input  logic [1:0]  mem_MemRead,
  input  logic        mem_LoadUnsigned,
  input  logic [4:0]  mem_Rw,
  input  logic        mem_RegWr,
  output logic        dm_req,
  output logic        dm_we,
  output logic [29:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_Rw,
  output logic        wb_RegWr,
  output logic [31:0] wb_data,
  output logic        exc_ades,
  output logic        exc_adel,
  output logic        exc_bus,
  output logic [31:0] exc_badvaddr
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {IDLE, ACCESS} state_t;
  state_t r_state, w_next;

  // Attributes of the access in flight; captured so ACCESS does not depend
  // on the EX/MEM register staying frozen.
  logic          r_st, r_uns, r_RegWr;
  logic [1:0]    r_size, r_off;
  logic [4:0]    r_Rw;
  logic [31:0]   r_addr;
  logic [CW-1:0] r_cnt;

  logic        w_st, w_acc, w_misal, w_tmo;
  logic [1:0]  w_size, w_a, w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_sh, w_ld;

  // Store wins when both MemWr and MemRead are set.
  assign w_st   = (mem_MemWr != 2'b00);
  assign w_acc  = mem_valid & (w_st | (mem_MemRead != 2'b00));
  assign w_size = w_st ? mem_MemWr : mem_MemRead;
  assign w_a    = mem_alu_result[1:0];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misal = ((w_size == 2'b10) & w_a[0]) | ((w_size == 2'b11) & (w_a != 2'b00));
`else
  assign w_misal = 1'b0;
`endif

  // Lane offset with the low bits masked to the access size.
  always_comb begin
    w_off = 2'b00;
    case (w_size)
      2'b01:   w_off = w_a;
      2'b10:   w_off = {w_a[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = mem_busB;
    case (w_size)
      2'b01: begin w_be = 4'b0001 << w_off; w_wdata = {4{mem_busB[7:0]}};  end
      2'b10: begin w_be = 4'b0011 << w_off; w_wdata = {2{mem_busB[15:0]}}; end
      2'b11: begin w_be = 4'b1111;          w_wdata = mem_busB;            end
      default: ;
    endcase
  end

  // Load extraction: move the addressed lane to bit 0, then extend.
  assign w_sh = dm_rdata >> {r_off, 3'b000};
  always_comb begin
    w_ld = w_sh;
    case (r_size)
      2'b01:   w_ld = r_uns ? {24'b0, w_sh[7:0]}  : {{24{w_sh[7]}}, w_sh[7:0]};
      2'b10:   w_ld = r_uns ? {16'b0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
      default: w_ld = w_sh;
    endcase
  end

  // Timeout fires on the edge where the no-ack count would reach the limit.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_nowd
      assign w_tmo = 1'b0;
    end else begin : g_wd
      assign w_tmo = (r_state == ACCESS) & ~dm_ack & (r_cnt == LAST);
    end
  endgenerate

  assign stall = ((r_state == IDLE) & w_acc & ~w_misal) |
                 ((r_state == ACCESS) & ~dm_ack & ~w_tmo);

  always_ff @(negedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc & ~w_misal) w_next = ACCESS;
      ACCESS:  if (dm_ack | w_tmo)   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(negedge Clk or negedge Reset) begin
    if (!Reset) begin
      dm_req <= 1'b0; dm_we <= 1'b0; dm_addr <= '0; dm_be <= '0; dm_wdata <= '0;
      wb_valid <= 1'b0; wb_Rw <= '0; wb_RegWr <= 1'b0; wb_data <= '0;
      exc_ades <= 1'b0; exc_adel <= 1'b0; exc_bus <= 1'b0; exc_badvaddr <= '0;
      r_st <= 1'b0; r_uns <= 1'b0; r_RegWr <= 1'b0; r_size <= '0; r_off <= '0;
      r_Rw <= '0; r_addr <= '0; r_cnt <= '0;
    end else begin
      // Write-back slot and exception flags are single-cycle pulses.
      wb_valid <= 1'b0; wb_RegWr <= 1'b0;
      exc_ades <= 1'b0; exc_adel <= 1'b0; exc_bus <= 1'b0; exc_badvaddr <= '0;
      case (r_state)
        IDLE: begin
          if (!w_acc) begin
            wb_valid <= mem_valid;
            wb_RegWr <= mem_RegWr & mem_valid;
            wb_Rw    <= mem_Rw;
            wb_data  <= mem_alu_result;
          end
`ifdef MEM_ALIGN_CHECK_EN
          else if (w_misal) begin
            wb_valid     <= 1'b1;
            wb_Rw        <= mem_Rw;
            wb_data      <= mem_alu_result;
            exc_ades     <= w_st;
            exc_adel     <= ~w_st;
            exc_badvaddr <= mem_alu_result;
          end
`endif
          else begin
            dm_req   <= 1'b1;
            dm_we    <= w_st;
            dm_addr  <= mem_alu_result[31:2];
            dm_be    <= w_be;
            dm_wdata <= w_wdata;
            r_st     <= w_st;
            r_uns    <= mem_LoadUnsigned;
            r_RegWr  <= mem_RegWr;
            r_size   <= w_size;
            r_off    <= w_off;
            r_Rw     <= mem_Rw;
            r_addr   <= mem_alu_result;
            r_cnt    <= '0;
          end
        end
        ACCESS: begin
          if (dm_ack || w_tmo) begin
            dm_req <= 1'b0; dm_we <= 1'b0; dm_addr <= '0; dm_be <= '0; dm_wdata <= '0;
            wb_valid <= 1'b1;
            wb_Rw    <= r_Rw;
          end
          if (dm_ack) begin
            wb_RegWr <= r_RegWr & ~r_st;
            wb_data  <= r_st ? r_addr : w_ld;
          end else if (w_tmo) begin
            wb_data      <= r_addr;
            exc_bus      <= 1'b1;
            exc_badvaddr <= r_addr;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
